mem_stage_unit: RTL and testbench
=================================

// Module: mem_stage_unit
// PURPOSE
//  MEM stage of the 5-stage pipeline; consumes the EX/MEM register outputs.
//  Runs data-memory loads/stores over a req/ack handshake and resolves beq/bne.
//  Stalls upstream stages while memory is busy.
//  Produces the registered MEM/WB fields: write enable, destination, selected data.
// PARAMETERS
//  DATA_W          32   datapath / memory data width
//  TIMEOUT_CYCLES  255  max WAIT cycles without DMemAck before abort (>=1)
// PORTS
//  CLOCK           in   1       rising-edge clock
//  RESET_N         in   1       asynchronous active-low reset
//  RegWriteEN_In   in   1       from EX/MEM: register write enable
//  Mem2RegSEL_In   in   2       00=ALU, 01=memory load, 10=PC+4 (jal), 11=ALU
//  MemWriteEN_In   in   1       store request
//  Beq_In/Bne_In   in   1 each  branch type
//  ZeroFlag_In     in   1       ALU zero flag
//  ALUResult_In    in   DATA_W  ALU result / memory address
//  WriteData_In    in   DATA_W  store data
//  RegWBAddr_In    in   5       destination register
//  PCPlus4_In      in   DATA_W  link value
//  DMemReq         out  1       memory request
//  DMemWE          out  1       1=store, 0=load
//  DMemAddr        out  DATA_W  = ALUResult_In
//  DMemWData       out  DATA_W  = WriteData_In
//  DMemRData       in   DATA_W  load data, valid when DMemAck=1
//  DMemAck         in   1       transfer complete
//  Stall_Out       out  1       freezes PC, IF/ID, ID/EX, EX/MEM
//  BranchTaken_Out out  1       (Beq_In&ZeroFlag_In)|(Bne_In&~ZeroFlag_In); flushes IF/ID, ID/EX
//  MemErr_Out      out  1       sticky error: timeout or misaligned access
//  RegWriteEN_Out  out  1       MEM/WB write enable
//  RegWBAddr_Out   out  5       MEM/WB destination
//  WBData_Out      out  DATA_W  MEM/WB write-back data, already muxed by Mem2RegSEL
//  StallCount_Out  out  32      stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Access condition: acc = MemWriteEN_In | (Mem2RegSEL_In==01).
//  - Misaligned access: acc with ALUResult_In[1:0]!=0.
//    -> no DMemReq; MemErr_Out set; instruction retires as a bubble.
//  - FSM has two states, IDLE and WAIT.
//    - DMemReq = (IDLE & acc & aligned) | WAIT.
//    - DMemWE  = MemWriteEN_In whenever DMemReq=1.
//  - IDLE:
//    - req & ack in the same cycle: zero-wait completion; stays IDLE.
//    - req & ~ack: go to WAIT; clear wait counter.
//  - WAIT:
//    - DMemAck=1: complete; go to IDLE.
//    - Counter reaches TIMEOUT_CYCLES: abort; go to IDLE; set MemErr_Out.
//      Instruction retires as a bubble (no store retry, no write-back).
//    - Otherwise: increment counter.
//  - Stall_Out = DMemReq & ~DMemAck & ~timeout_abort (combinational).
//  - Upstream holds EX/MEM stable while Stall_Out=1; addr/data/WE stay stable during WAIT.
//  - MEM/WB register updates every cycle:
//    - Stall_Out=1 or bubble: RegWriteEN_Out<=0; RegWBAddr_Out/WBData_Out hold.
//    - Otherwise: RegWriteEN_Out<=RegWriteEN_In; RegWBAddr_Out<=RegWBAddr_In.
//      WBData_Out <= DMemRData (01), PCPlus4_In (10), else ALUResult_In.
//  - Latency: 1 cycle from completion to MEM/WB; a k-wait access stalls exactly k cycles.
//  - BranchTaken_Out is combinational. Branches never access memory, so never stall.
//    Asserted for exactly one cycle per taken branch.
//  - Reset (async, any state including WAIT):
//    - state=IDLE; counter=0.
//    - DMemReq, Stall_Out and all registered outputs drop to 0 immediately.
//    - MemErr_Out=0; StallCount_Out=0.
//  - MemErr_Out is cleared only by reset.
// CONFIGURATION
//  MEM_STALL_CNT_EN defined:
//    StallCount_Out increments each cycle Stall_Out=1; saturates at 32'hFFFF_FFFF.
//  Undefined:
//    StallCount_Out tied to 0; counter logic absent.
// TESTING
//  1 Zero-wait load: Mem2RegSEL=01, addr 0x10, Ack same cycle, RData=0xDEADBEEF.
//    -> Stall never high; next cycle RegWriteEN_Out=1, WBData_Out=0xDEADBEEF.
//  2 Store, ack after 3 cycles: addr 0x20, data 0x55.
//    -> Stall_Out high 3 cycles; DMemReq/Addr/WData stable throughout; RegWriteEN_Out=0.
//  3 Load, Ack never arrives, TIMEOUT_CYCLES=4.
//    -> abort after 4 WAIT cycles; MemErr_Out=1 sticky; no write-back.
//  4 Misaligned load at addr 0x13.
//    -> DMemReq stays 0; MemErr_Out=1; bubble.
//  5 Bne_In=1, ZeroFlag_In=0 -> BranchTaken_Out=1 that cycle.
//    Beq_In=1, ZeroFlag_In=0 -> BranchTaken_Out=0.
//  6 jal: Mem2RegSEL=10, PCPlus4=0x404, RegWBAddr=31 -> WBData_Out=0x404, RegWBAddr_Out=31.
//  7 RESET_N low mid-WAIT -> DMemReq and Stall_Out drop at once; state IDLE.
//    With MEM_STALL_CNT_EN defined: StallCount_Out=0.

Source files
------------

// File: rtl/mem_stage_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_unit_if #(
  parameter int DATA_W = 32
);
  logic              DMemReq;
  logic              DMemWE;
  logic [DATA_W-1:0] DMemAddr;
  logic [DATA_W-1:0] DMemWData;
  logic [DATA_W-1:0] DMemRData;
  logic              DMemAck;

  modport master (
    output DMemReq,
    output DMemWE,
    output DMemAddr,
    output DMemWData,
    input  DMemRData,
    input  DMemAck
  );

  modport slave (
    input  DMemReq,
    input  DMemWE,
    input  DMemAddr,
    input  DMemWData,
    output DMemRData,
    output DMemAck
  );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: data-memory loads/stores over req/ack, beq/bne resolution, MEM/WB register.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_stage_unit #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              RegWriteEN_In,
  input  logic [1:0]        Mem2RegSEL_In,
  input  logic              MemWriteEN_In,
  input  logic              Beq_In,
  input  logic              Bne_In,
  input  logic              ZeroFlag_In,
  input  logic [DATA_W-1:0] ALUResult_In,
  input  logic [DATA_W-1:0] WriteData_In,
  input  logic [4:0]        RegWBAddr_In,
  input  logic [DATA_W-1:0] PCPlus4_In,
  mem_stage_unit_if.master  dmem,
  output logic              Stall_Out,
  output logic              BranchTaken_Out,
  output logic              MemErr_Out,
  output logic              RegWriteEN_Out,
  output logic [4:0]        RegWBAddr_Out,
  output logic [DATA_W-1:0] WBData_Out,
  output logic [31:0]       StallCount_Out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the WAIT cycle whose counter value is TIMEOUT_CYCLES-1,
  // so exactly TIMEOUT_CYCLES WAIT cycles elapse without an acknowledge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic is_load;
  logic acc;
  logic misaligned;
  logic in_wait;
  logic mem_req;
  logic timeout_abort;
  logic stall;
  logic bubble;

  always_comb begin
    is_load       = (Mem2RegSEL_In == 2'b01);
    acc           = MemWriteEN_In | is_load;
    in_wait       = (state_q == ST_WAIT);
    misaligned    = ~in_wait & acc & (ALUResult_In[1:0] != 2'b00);
    // Gated by reset so the request drops the instant reset asserts.
    mem_req       = RESET_N & (in_wait | (acc & ~misaligned));
    timeout_abort = in_wait & ~dmem.DMemAck & (wait_cnt_q == CNT_LAST);
    stall         = mem_req & ~dmem.DMemAck & ~timeout_abort;
    bubble        = misaligned | timeout_abort;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !dmem.DMemAck) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (dmem.DMemAck) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (timeout_abort) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // MEM/WB: write enable drops on stall or bubble; destination and data hold.
  always_comb begin
    wen_d     = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = err_q | bubble;
    if (!stall && !bubble) begin
      wen_d     = RegWriteEN_In;
      wb_addr_d = RegWBAddr_In;
      case (Mem2RegSEL_In)
        2'b01:   wb_data_d = dmem.DMemRData;
        2'b10:   wb_data_d = PCPlus4_In;
        default: wb_data_d = ALUResult_In;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      wen_q      <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      wen_q      <= wen_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount_Out = stall_cnt_q;
`else
  assign StallCount_Out = 32'd0;
`endif

  assign dmem.DMemReq   = mem_req;
  assign dmem.DMemWE    = mem_req & MemWriteEN_In;
  assign dmem.DMemAddr  = ALUResult_In;
  assign dmem.DMemWData = WriteData_In;

  assign Stall_Out       = stall;
  assign BranchTaken_Out = (Beq_In & ZeroFlag_In) | (Bne_In & ~ZeroFlag_In);
  assign MemErr_Out      = err_q;
  assign RegWriteEN_Out  = wen_q;
  assign RegWBAddr_Out   = wb_addr_q;
  assign WBData_Out      = wb_data_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: per-cycle behavioural model plus hand-computed literal checks.
module tb_mem_stage_unit;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          CLOCK = 1'b0;
  logic          RESET_N;
  logic          RegWriteEN_In;
  logic [1:0]    Mem2RegSEL_In;
  logic          MemWriteEN_In;
  logic          Beq_In;
  logic          Bne_In;
  logic          ZeroFlag_In;
  logic [DW-1:0] ALUResult_In;
  logic [DW-1:0] WriteData_In;
  logic [4:0]    RegWBAddr_In;
  logic [DW-1:0] PCPlus4_In;
  logic          Stall_Out;
  logic          BranchTaken_Out;
  logic          MemErr_Out;
  logic          RegWriteEN_Out;
  logic [4:0]    RegWBAddr_Out;
  logic [DW-1:0] WBData_Out;
  logic [31:0]   StallCount_Out;

  always #5 CLOCK = ~CLOCK;

  mem_stage_unit_if #(.DATA_W(DW)) dmem ();

  mem_stage_unit #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK          (CLOCK),
    .RESET_N        (RESET_N),
    .RegWriteEN_In  (RegWriteEN_In),
    .Mem2RegSEL_In  (Mem2RegSEL_In),
    .MemWriteEN_In  (MemWriteEN_In),
    .Beq_In         (Beq_In),
    .Bne_In         (Bne_In),
    .ZeroFlag_In    (ZeroFlag_In),
    .ALUResult_In   (ALUResult_In),
    .WriteData_In   (WriteData_In),
    .RegWBAddr_In   (RegWBAddr_In),
    .PCPlus4_In     (PCPlus4_In),
    .dmem           (dmem),
    .Stall_Out      (Stall_Out),
    .BranchTaken_Out(BranchTaken_Out),
    .MemErr_Out     (MemErr_Out),
    .RegWriteEN_Out (RegWriteEN_Out),
    .RegWBAddr_Out  (RegWBAddr_Out),
    .WBData_Out     (WBData_Out),
    .StallCount_Out (StallCount_Out)
  );

  int checks = 0;
  int failures = 0;

  // Model state: what the MEM/WB register and sticky flags must hold after the next edge.
  int          m_pending;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] m_scnt;
  int          stall_seen;
  int          req_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic acc, mis, pend, e_req, abort, e_stall, e_br;
    logic [31:0] e_cnt;
    if (!RESET_N) begin
      m_pending = 0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0; m_scnt = '0;
      chk("rst_req",   dmem.DMemReq,   32'd0);
      chk("rst_stall", Stall_Out,      32'd0);
      chk("rst_wen",   RegWriteEN_Out, 32'd0);
      chk("rst_waddr", RegWBAddr_Out,  32'd0);
      chk("rst_wdata", WBData_Out,     32'd0);
      chk("rst_err",   MemErr_Out,     32'd0);
      chk("rst_scnt",  StallCount_Out, 32'd0);
    end else begin
      pend    = (m_pending > 0);
      acc     = MemWriteEN_In | (Mem2RegSEL_In == 2'b01);
      mis     = !pend && acc && (ALUResult_In % 4 != 0);
      e_req   = pend || (acc && !mis);
      abort   = pend && !dmem.DMemAck && (m_pending == TO);
      e_stall = e_req && !dmem.DMemAck && !abort;
      e_br    = (Beq_In && ZeroFlag_In) || (Bne_In && !ZeroFlag_In);
`ifdef MEM_STALL_CNT_EN
      e_cnt = m_scnt;
`else
      e_cnt = 32'd0;
`endif
      chk("m_req",    dmem.DMemReq,   {31'd0, e_req});
      chk("m_we",     dmem.DMemWE,    {31'd0, e_req && MemWriteEN_In});
      chk("m_addr",   dmem.DMemAddr,  ALUResult_In);
      chk("m_wdata",  dmem.DMemWData, WriteData_In);
      chk("m_stall",  Stall_Out,      {31'd0, e_stall});
      chk("m_branch", BranchTaken_Out,{31'd0, e_br});
      chk("m_wen",    RegWriteEN_Out, {31'd0, m_wen});
      chk("m_wbaddr", RegWBAddr_Out,  {27'd0, m_addr});
      chk("m_wbdata", WBData_Out,     m_data);
      chk("m_err",    MemErr_Out,     {31'd0, m_err});
      chk("m_scnt",   StallCount_Out, e_cnt);
      if (Stall_Out) stall_seen++;
      if (dmem.DMemReq) req_seen++;
      if (e_stall || mis || abort) begin
        m_wen = 1'b0;
      end else begin
        m_wen  = RegWriteEN_In;
        m_addr = RegWBAddr_In;
        if (Mem2RegSEL_In == 2'b01)      m_data = dmem.DMemRData;
        else if (Mem2RegSEL_In == 2'b10) m_data = PCPlus4_In;
        else                             m_data = ALUResult_In;
      end
      if (mis || abort) m_err = 1'b1;
      if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      m_pending = e_stall ? m_pending + 1 : 0;
    end
  endtask

  task automatic set_nop();
    RegWriteEN_In = 1'b0; Mem2RegSEL_In = 2'b00; MemWriteEN_In = 1'b0;
    Beq_In = 1'b0; Bne_In = 1'b0; ZeroFlag_In = 1'b0;
    ALUResult_In = '0; WriteData_In = '0; RegWBAddr_In = '0; PCPlus4_In = '0;
    dmem.DMemAck = 1'b0; dmem.DMemRData = '0;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Holds one EX/MEM instruction for 'hold' cycles, acknowledging on cycle ack_at (-1: never).
  task automatic run_op(input logic rw, input logic [1:0] sel, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] pc4, input logic [31:0] rdata,
                        input int ack_at, input int hold);
    RegWriteEN_In = rw; Mem2RegSEL_In = sel; MemWriteEN_In = mw;
    Beq_In = 1'b0; Bne_In = 1'b0; ZeroFlag_In = 1'b0;
    ALUResult_In = alu; WriteData_In = wd; RegWBAddr_In = rd; PCPlus4_In = pc4;
    for (int c = 0; c < hold; c++) begin
      dmem.DMemAck   = (c == ack_at);
      dmem.DMemRData = (c == ack_at) ? rdata : (32'hBAD0_0000 | c);
      step();
    end
    set_nop();
  endtask

  int s0, r0;

  initial begin
    set_nop();
    RESET_N = 1'b0;
    fork
      forever begin
        @(negedge CLOCK);
        compare();
      end
    join_none

    repeat (2) step();
    chk("reset_wen", RegWriteEN_Out, 32'd0);
    chk("reset_err", MemErr_Out, 32'd0);
    RESET_N = 1'b1;
    step();

    // Zero-wait load
    s0 = stall_seen;
    run_op(1'b1, 2'b01, 1'b0, 32'h10, 32'h0, 5'd5, 32'h0, 32'hDEADBEEF, 0, 1);
    chk("t1_wen",   RegWriteEN_Out, 32'd1);
    chk("t1_data",  WBData_Out, 32'hDEADBEEF);
    chk("t1_waddr", RegWBAddr_Out, 32'd5);
    chk("t1_stall", stall_seen - s0, 32'd0);

    // jal link
    run_op(1'b1, 2'b10, 1'b0, 32'h77, 32'h0, 5'd31, 32'h404, 32'h0, -1, 1);
    chk("t6_data",  WBData_Out, 32'h404);
    chk("t6_waddr", RegWBAddr_Out, 32'd31);

    // ALU result via select 11
    run_op(1'b1, 2'b11, 1'b0, 32'h1235, 32'h0, 5'd7, 32'h999, 32'h0, -1, 1);
    chk("alu_data", WBData_Out, 32'h1235);

    // Branches
    Bne_In = 1'b1; ZeroFlag_In = 1'b0; #2;
    chk("t5_bne_taken", BranchTaken_Out, 32'd1);
    chk("t5_bne_stall", Stall_Out, 32'd0);
    step();
    Bne_In = 1'b0; Beq_In = 1'b1; ZeroFlag_In = 1'b0; #2;
    chk("t5_beq_not", BranchTaken_Out, 32'd0);
    step();
    ZeroFlag_In = 1'b1; #2;
    chk("t5_beq_taken", BranchTaken_Out, 32'd1);
    step();
    set_nop(); #2;
    chk("t5_branch_drop", BranchTaken_Out, 32'd0);
    step();

    // Store acknowledged after 3 wait cycles
    s0 = stall_seen; r0 = req_seen;
    run_op(1'b0, 2'b00, 1'b1, 32'h20, 32'h55, 5'd3, 32'h0, 32'h0, 3, 4);
    chk("t2_stall_cycles", stall_seen - s0, 32'd3);
    chk("t2_req_cycles",   req_seen - r0, 32'd4);
    chk("t2_wen",          RegWriteEN_Out, 32'd0);

    // Load acknowledged after 2 wait cycles
    s0 = stall_seen;
    run_op(1'b1, 2'b01, 1'b0, 32'h84, 32'h0, 5'd12, 32'h0, 32'hCAFEF00D, 2, 3);
    chk("kload_stall", stall_seen - s0, 32'd2);
    chk("kload_wen",   RegWriteEN_Out, 32'd1);
    chk("kload_data",  WBData_Out, 32'hCAFEF00D);

    // Load timeout
    chk("t3_err_before", MemErr_Out, 32'd0);
    s0 = stall_seen;
    run_op(1'b1, 2'b01, 1'b0, 32'h40, 32'h0, 5'd9, 32'h0, 32'h0, -1, TO + 1);
    chk("t3_stall_cycles", stall_seen - s0, 32'd4);
    chk("t3_err",   MemErr_Out, 32'd1);
    chk("t3_wen",   RegWriteEN_Out, 32'd0);
    chk("t3_data",  WBData_Out, 32'hCAFEF00D);
    repeat (2) step();
    chk("t3_err_sticky", MemErr_Out, 32'd1);

    // Reset asserted mid-WAIT
    RegWriteEN_In = 1'b1; Mem2RegSEL_In = 2'b01; ALUResult_In = 32'h60; RegWBAddr_In = 5'd2;
    repeat (2) step();
    RESET_N = 1'b0; #1;
    chk("t7_req",   dmem.DMemReq, 32'd0);
    chk("t7_stall", Stall_Out, 32'd0);
    chk("t7_err",   MemErr_Out, 32'd0);
    chk("t7_scnt",  StallCount_Out, 32'd0);
    step();
    set_nop();
    RESET_N = 1'b1;
    step();
    run_op(1'b1, 2'b00, 1'b0, 32'hABC, 32'h0, 5'd8, 32'h0, 32'h0, -1, 1);
    chk("t7_after_wen",  RegWriteEN_Out, 32'd1);
    chk("t7_after_data", WBData_Out, 32'hABC);

    // Misaligned load
    r0 = req_seen;
    run_op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0, 5'd4, 32'h0, 32'h11111111, 0, 1);
    chk("t4_req",  req_seen - r0, 32'd0);
    chk("t4_err",  MemErr_Out, 32'd1);
    chk("t4_wen",  RegWriteEN_Out, 32'd0);
    chk("t4_data", WBData_Out, 32'hABC);
    repeat (2) step();
    chk("t4_err_sticky", MemErr_Out, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
